// File: rtl/spi_sync_slave.sv
// rtl/spi_sync_slave.sv - SPI mode-0 register slave with clk-domain synchronizers
`timescale 1ns/1ps
module spi_sync_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ss,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic       spioe,
  output logic [3:0] addr,
  output logic [7:0] wrtdata,
  input  logic [7:0] rddata,
  output logic       rdt,
  output logic       wrt
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   sclk_dly_q;
  logic                   ss_s, sclk_s, mosi_s;
  logic                   sclk_rise, sclk_fall;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [6:0]  in_sr_q;
  logic [7:0]  in_sr_d;
  logic [6:0]  out_sr_q;
  logic [1:0]  rd_step_q;
  logic        wr_q;
  logic        armed_q;
  logic        miso_q, rdt_q, wrt_q;
  logic [3:0]  addr_q;
  logic [7:0]  wrtdata_q;

  // Reset values make the synchronized view look like an idle bus (ss high, sclk low).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ss_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign in_sr_d   = {in_sr_q, mosi_s};

  // armed_q demands a seen-high ss before a frame, so reset never starts one mid-burst.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      in_sr_q   <= 7'd0;
      out_sr_q  <= 7'd0;
      rd_step_q <= 2'd0;
      wr_q      <= 1'b0;
      armed_q   <= 1'b0;
      miso_q    <= 1'b0;
      rdt_q     <= 1'b0;
      wrt_q     <= 1'b0;
      addr_q    <= 4'h0;
      wrtdata_q <= 8'h00;
    end else if (ss_s) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      rd_step_q <= 2'd0;
      armed_q   <= 1'b1;
      miso_q    <= 1'b0;
      rdt_q     <= 1'b0;
      wrt_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (armed_q) begin
            state_q <= ADDR;
            cnt_q   <= 4'd0;
            miso_q  <= 1'b0;
            armed_q <= 1'b0;
          end
        end
        ADDR: begin
          if (sclk_rise) begin
            in_sr_q <= in_sr_d[6:0];
            cnt_q   <= cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              addr_q    <= in_sr_d[3:0];
              wr_q      <= in_sr_d[7];
              rd_step_q <= in_sr_d[7] ? 2'd0 : 2'd1;
              state_q   <= DATA;
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            in_sr_q <= in_sr_d[6:0];
            cnt_q   <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_q <= DONE;
              miso_q  <= 1'b0;
              if (wr_q) begin
                wrtdata_q <= in_sr_d;
                wrt_q     <= 1'b1;
              end
            end
          end
          if (!wr_q) begin
            case (rd_step_q)
              2'd1: begin
                rdt_q     <= 1'b1;
                rd_step_q <= 2'd2;
              end
              2'd2: begin
                miso_q    <= rddata[7];
                out_sr_q  <= rddata[6:0];
                rd_step_q <= 2'd3;
              end
              // bit7 is already on miso for rise 9, so the fall right after rise 8 holds it.
              2'd3: begin
                if (sclk_fall && cnt_q != 4'd8) begin
                  miso_q   <= out_sr_q[6];
                  out_sr_q <= {out_sr_q[5:0], 1'b0};
                end
              end
              default: ;
            endcase
          end
        end
        DONE: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spioe   = ~ss_s;
  assign miso    = miso_q;
  assign rdt     = rdt_q;
  assign wrt     = wrt_q;
  assign addr    = addr_q;
  assign wrtdata = wrtdata_q;

endmodule

// File: tb/tb_spi_sync_slave.sv
// tb/tb_spi_sync_slave.sv - randomized scoreboard bench for spi_sync_slave
`timescale 1ns/1ps
module tb_spi_sync_slave;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ss = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       miso, spioe, rdt, wrt;
  logic [3:0] addr;
  logic [7:0] wrtdata, rddata;

  logic [7:0] mem [16];
  assign rddata = mem[addr];

  always #5 clk = ~clk;

  spi_sync_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .resetn(resetn), .ss(ss), .sclk(sclk), .mosi(mosi),
    .miso(miso), .spioe(spioe), .addr(addr), .wrtdata(wrtdata),
    .rddata(rddata), .rdt(rdt), .wrt(wrt)
  );

  typedef struct {
    bit         is_wr;
    logic [3:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] got_rd_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] m_addr = 4'h0;
  logic [7:0] m_wrtdata = 8'h00;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, expv, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Reference model: what a frame of nbits rises should produce.
  task automatic issue(input logic [7:0] b0, input logic [7:0] b1, input int nbits);
    if (nbits >= 8) begin
      m_addr = b0[3:0];
      if (!b0[7]) begin
        exp_q.push_back('{is_wr: 1'b0, a: b0[3:0], d: 8'h00});
        if (nbits >= 16) exp_rd_q.push_back(mem[b0[3:0]]);
      end else if (nbits >= 16) begin
        m_wrtdata = b1;
        exp_q.push_back('{is_wr: 1'b1, a: b0[3:0], d: b1});
      end
    end
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input int nbits,
                       input int h, input bit raise, input bit timing);
    logic [15:0] fr;
    logic [7:0]  rx;
    fr = {b0, b1};
    rx = 8'h00;
    ss = 1'b0;
    wait_clk(h);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? fr[15-i] : 1'($urandom);
      wait_clk(h);
      if (i >= 8 && i < 16) rx = {rx[6:0], miso};
      sclk = 1'b1;
      if (timing && i == 15) begin
        repeat (2) @(posedge clk);
        #1 chk("wrt_before_latency", wrt, 0);
        @(posedge clk);
        #1 chk("wrt_at_latency", wrt, 1);
        wait_clk(h - 3);
      end else begin
        wait_clk(h);
      end
      sclk = 1'b0;
    end
    if (raise) begin
      wait_clk(h);
      ss = 1'b1;
      if (timing) begin
        repeat (2) @(posedge clk);
        #1 chk("wrt_hold_after_ss", wrt, 1);
        @(posedge clk);
        #1 chk("wrt_clear_after_ss", wrt, 0);
      end
      if (!b0[7] && nbits >= 16) got_rd_q.push_back(rx);
    end
  endtask

  task automatic post_checks(input string tag);
    chk({tag, "_addr"}, addr, m_addr);
    chk({tag, "_wrtdata"}, wrtdata, m_wrtdata);
    chk({tag, "_rdt_idle"}, rdt, 0);
    chk({tag, "_wrt_idle"}, wrt, 0);
    chk({tag, "_miso_idle"}, miso, 0);
  endtask

  logic rdt_p = 1'b0;
  logic wrt_p = 1'b0;

  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] g, x;
    if (wrt && !wrt_p) begin
      chk("wrt_rdt_exclusive", rdt, 0);
      chk("wrt_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wrt_kind", wrt, e.is_wr);
        chk("wrt_addr", addr, e.a);
        chk("wrt_data", wrtdata, e.d);
      end
    end
    if (rdt && !rdt_p) begin
      chk("rdt_wrt_exclusive", wrt, 0);
      chk("rdt_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rdt_kind", !rdt, e.is_wr);
        chk("rdt_addr", addr, e.a);
      end
    end
    if (got_rd_q.size() != 0) begin
      g = got_rd_q.pop_front();
      chk("rd_data_expected", exp_rd_q.size() != 0, 1);
      if (exp_rd_q.size() != 0) begin
        x = exp_rd_q.pop_front();
        chk("rd_data", g, x);
      end
    end
    rdt_p <= rdt;
    wrt_p <= wrt;
  end

  initial begin
    int         nbits, r, h;
    logic [7:0] b0, b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    mem[1] = 8'h3C;
    mem[5] = 8'hC3;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_miso", miso, 0);
    chk("rst_spioe", spioe, 0);
    chk("rst_rdt", rdt, 0);
    chk("rst_wrt", wrt, 0);
    chk("rst_addr", addr, 4'h0);
    chk("rst_wrtdata", wrtdata, 8'h00);
    wait_clk(1);
    resetn = 1'b1;
    wait_clk(4);

    issue(8'h80, 8'hA5, 16);
    frame(8'h80, 8'hA5, 16, 8, 1'b1, 1'b1);
    wait_clk(4);
    post_checks("wr_a5");

    issue(8'h01, 8'h00, 16);
    frame(8'h01, 8'h00, 16, 8, 1'b1, 1'b0);
    wait_clk(4);
    post_checks("rd_3c");

    issue(8'h8F, 8'h33, 12);
    frame(8'h8F, 8'h33, 12, 8, 1'b1, 1'b0);
    wait_clk(4);
    post_checks("abort_wr");

    issue(8'h8E, 8'h55, 24);
    frame(8'h8E, 8'h55, 24, 8, 1'b1, 1'b0);
    wait_clk(4);
    post_checks("wr_24bits");

    issue(8'h05, 8'h00, 12);
    frame(8'h05, 8'h00, 12, 8, 1'b0, 1'b0);
    wait_clk(2);
    chk("pre_reset_rdt", rdt, 1);
    resetn = 1'b0;
    #1;
    chk("reset_rdt", rdt, 0);
    chk("reset_miso", miso, 0);
    m_addr = 4'h0;
    m_wrtdata = 8'h00;
    wait_clk(3);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mosi = 1'($urandom);
      wait_clk(8);
      sclk = 1'b1;
      wait_clk(8);
      sclk = 1'b0;
    end
    chk("post_reset_rdt", rdt, 0);
    chk("post_reset_wrt", wrt, 0);
    chk("post_reset_miso", miso, 0);
    ss = 1'b1;
    wait_clk(6);
    post_checks("after_reset");

    for (int k = 0; k < 40; k++) begin
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      r = $urandom_range(0, 9);
      nbits = (r == 0) ? $urandom_range(1, 15) : (r == 1) ? $urandom_range(17, 24) : 16;
      h = $urandom_range(8, 11);
      issue(b0, b1, nbits);
      frame(b0, b1, nbits, h, 1'b1, 1'b0);
      wait_clk(4);
      post_checks("rand");
    end

    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && exp_rd_q.size() == 0 && got_rd_q.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_exp_q", exp_q.size(), 0);
    chk("drain_exp_rd_q", exp_rd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_sync_slave.md
SPI_SYNC_SLAVE -- requirements
Module: spi_sync_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for sclk, ss and mosi (legal 2..3).
REQ-002 SHALL have port clk, input, 1, system clock; all state on its rising edge.
REQ-003 SHALL have port resetn, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port ss, input, 1, SPI slave select, active-low, asynchronous to clk.
REQ-005 SHALL have port sclk, input, 1, SPI clock (mode 0), asynchronous to clk.
REQ-006 SHALL have port mosi, input, 1, data from master.
REQ-007 SHALL have port miso, output, 1, data to master.
REQ-008 SHALL have port spioe, output, 1, miso output enable for the external tristate.
REQ-009 SHALL have port addr, output, 4, register address of the current or last frame.
REQ-010 SHALL have port wrtdata, output, 8, write data of the last write frame.
REQ-011 SHALL have port rddata, input, 8, read data from the address decoder, combinational from addr.
REQ-012 SHALL have port rdt, output, 1, read transaction level.
REQ-013 SHALL have port wrt, output, 1, write transaction level; the downstream falling-edge detector forms the write enable.

Function
REQ-014 SHALL pass ss, sclk and mosi through SYNC_STAGES flops each, then detect sclk rise and fall from the synchronized value and one extra flop.
REQ-015 SHALL meet all timing for clk frequency >= 16x sclk; behaviour below that ratio is undefined.
REQ-016 SHALL use a 16-bit frame, MSB first:
- Byte 0: bit7 = W (1 = write, 0 = read), bits 6:4 ignored, bits 3:0 = address.
- Byte 1: data (mosi for write, miso for read).
REQ-017 SHALL implement states IDLE, ADDR, DATA, DONE with a 4-bit bit counter.
REQ-018 SHALL transition IDLE->ADDR on synchronized ss low; bit counter cleared; miso = 0.
REQ-019 SHALL, in ADDR, shift mosi in on each detected sclk rise; on the 8th rise, latch addr and the W bit and go to DATA.
REQ-020 SHALL, for a read, assert rdt the clk after addr is latched, sample rddata into the 8-bit output shift register one clk later, and drive its bit7 on miso immediately.
REQ-021 SHALL, for a read in DATA, shift the output register on each detected sclk fall so that the next bit appears on miso; mosi is ignored.
REQ-022 SHALL, for a write in DATA, shift mosi in on each rise; on the 16th rise, update wrtdata and assert wrt the same clk.
REQ-023 SHALL go DATA->DONE on the 16th rise; DONE ignores further sclk edges while ss is low.
REQ-024 SHALL, on synchronized ss high in any state, return to IDLE the next clk and clear rdt, wrt and the bit counter.
REQ-025 SHALL retain addr and wrtdata across frames, including aborted ones.
REQ-026 SHALL, if ss rises before the 16th rise of a write, not assert wrt and leave wrtdata unchanged.
REQ-027 SHALL hold rdt and wrt high only until ss deasserts; rdt and wrt are never both high.
REQ-028 SHALL drive spioe = synchronized ss inverted; miso = 0 whenever not in a read DATA state.
REQ-029 SHALL give latency from a pin sclk edge to the internal action of SYNC_STAGES + 1 clk.

Reset
REQ-030 SHALL, while resetn is low, force:
- state IDLE, bit counter 0;
- miso 0, spioe 0, rdt 0, wrt 0;
- addr 4'h0, wrtdata 8'h00;
- synchronizer flops to ss = 1, sclk = 0, mosi = 0.
REQ-031 SHALL, on reset assertion mid-frame, abort the frame with no wrt pulse; after release, begin a new frame only on a fresh ss high-to-low transition.

Verification
REQ-032 SHALL pass: write frame 8'h80, 8'hA5 with clk = 16x sclk -> addr = 0, wrtdata = 8'hA5, wrt high from the 16th rise + 3 clk until ss high + 3 clk.
REQ-033 SHALL pass: read frame 8'h01 with rddata = 8'h3C -> rdt asserted after the 8th rise; master shifts in 8'h3C; addr = 1; wrt stays 0.
REQ-034 SHALL pass: write 8'h8F then ss raised after 12 bits -> wrt never asserts, wrtdata keeps its previous value, state returns to IDLE.
REQ-035 SHALL pass: 24 sclk cycles in one ss-low window on write 8'h8E, 8'h55 -> wrtdata = 8'h55; extra bits ignored; a single wrt level.
REQ-036 SHALL pass: resetn pulsed low during DATA of a read -> rdt = 0 and miso = 0 immediately; no transaction on the next clk after release until ss toggles.
REQ-037 SHALL pass: back-to-back frames with ss high for 4 clk between them -> both transactions complete correctly; rdt or wrt deasserts between them.
